vga_sync_gen: RTL and testbench

//   Pixel-coordinate source for the text display path: generates VGA hsync/vsync, the

---
 rtl/vga_sync_gen.sv | 115 +++++++++++
 tb/tb_vga_sync_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
//   Pixel-coordinate source for the text display path. Divides the system
//   clock down to a pixel tick, scans pixel_x/pixel_y through a parameterised
//   VGA timing (640x480@60 by default) and produces hsync/vsync aligned with
//   the coordinates, plus video_on and line/frame boundary flags.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous reset, active-low (0 = reset)
//   p_tick       out  one-clk pixel enable, once every CLK_DIV clocks
//   pixel_x      out  current column, 0..H_TOTAL-1
//   pixel_y      out  current row, 0..V_TOTAL-1
//   video_on     out  high inside the visible H_DISPLAY x V_DISPLAY area
//   hsync        out  horizontal sync, active level SYNC_POL
//   vsync        out  vertical sync, active level SYNC_POL
//   line_end     out  high while pixel_x == H_TOTAL-1
//   frame_start  out  high while pixel_x == 0 and pixel_y == 0
// ----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CLK_DIV   = 2,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_end,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Coordinates are 10 bits wide; larger timings would silently alias.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]       HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]       HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]       VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]       VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             hsync_next;
    logic             vsync_next;

    assign p_tick = (div_cnt == DIV_MAX);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        div_next = p_tick ? '0 : div_cnt + 1'b1;
        x_next   = pixel_x;
        y_next   = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_MAX) begin
                x_next = '0;
                y_next = (pixel_y == V_MAX) ? 10'd0 : pixel_y + 10'd1;
            end else begin
                x_next = pixel_x + 10'd1;
            end
        end
        // Sync registers are loaded from the next coordinates so that they
        // line up with pixel_x/pixel_y with no extra cycle of latency.
        hsync_next = (x_next >= HS_START && x_next <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_next = (y_next >= VS_START && y_next <= VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            pixel_x <= '0;
            pixel_y <= '0;
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
        end else begin
            div_cnt <= div_next;
            pixel_x <= x_next;
            pixel_y <= y_next;
            hsync   <= hsync_next;
            vsync   <= vsync_next;
        end
    end

    assign video_on    = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    assign line_end    = (pixel_x == H_MAX);
    assign frame_start = (pixel_x == 10'd0) && (pixel_y == 10'd0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Two instances share clock and reset: dut_a uses the default 640x480
//   timing (CLK_DIV=2, active-low sync); dut_b uses a tiny 32x19 timing with
//   CLK_DIV=3 and active-high sync so that whole frames fit in a short run.
//   Expected outputs come from the clock count since reset release:
//   pixel number = clocks / CLK_DIV, position = that number modulo the frame.
// ----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    logic       a_pt, a_von, a_hs, a_vs, a_le, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_von, b_hs, b_vs, b_le, b_fs;
    logic [9:0] b_x, b_y;

    vga_sync_gen dut_a (
        .clk(clk), .reset(reset), .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y),
        .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .line_end(a_le),
        .frame_start(a_fs)
    );

    vga_sync_gen #(
        .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(3), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y),
        .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .line_end(b_le),
        .frame_start(b_fs)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Clocks elapsed since reset release; zero while reset is held.
    int k = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    // Behavioural reference: position from the tick count, flags from ranges.
    function automatic logic [31:0] model(input int d, input int hd, input int hf,
                                          input int hsw, input int hb, input int vd,
                                          input int vf, input int vsw, input int vb,
                                          input logic pol, input int clks);
        int ht, vt, n, x, y;
        logic pt, von, hs, vs, le, fs;
        ht  = hd + hf + hsw + hb;
        vt  = vd + vf + vsw + vb;
        n   = clks / d;
        x   = n % ht;
        y   = (n / ht) % vt;
        pt  = (clks % d) == d - 1;
        von = (x < hd) && (y < vd);
        hs  = (x >= hd + hf && x < hd + hf + hsw) ? pol : ~pol;
        vs  = (y >= vd + vf && y < vd + vf + vsw) ? pol : ~pol;
        le  = (x == ht - 1);
        fs  = (x == 0) && (y == 0);
        return {6'b0, pt, von, hs, vs, le, fs, 10'(x), 10'(y)};
    endfunction

    function automatic logic [31:0] pack(input logic pt, input logic von, input logic hs,
                                         input logic vs, input logic le, input logic fs,
                                         input logic [9:0] x, input logic [9:0] y);
        return {6'b0, pt, von, hs, vs, le, fs, x, y};
    endfunction

    // Window counters over the first B frame / first A line after release.
    logic counting = 1'b0;
    int   b_von_ticks = 0, b_hs_ticks = 0, b_vs_ticks = 0, a_hs_clks = 0;

    always @(negedge clk) begin
        check("A_cycle", pack(a_pt, a_von, a_hs, a_vs, a_le, a_fs, a_x, a_y),
              model(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, k));
        check("B_cycle", pack(b_pt, b_von, b_hs, b_vs, b_le, b_fs, b_x, b_y),
              model(3, 20, 3, 5, 4, 12, 2, 2, 3, 1'b1, k));
        if (counting && reset) begin
            if (k < 1824 && b_pt) begin
                if (b_von)         b_von_ticks++;
                if (b_hs === 1'b1) b_hs_ticks++;
                if (b_vs === 1'b1) b_vs_ticks++;
            end
            if (k < 1600 && a_hs === 1'b0) a_hs_clks++;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_A"}, pack(a_pt, a_von, a_hs, a_vs, a_le, a_fs, a_x, a_y),
              {6'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0});
        check({tag, "_B"}, pack(b_pt, b_von, b_hs, b_vs, b_le, b_fs, b_x, b_y),
              {6'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0});
    endtask

    // Advance to the negedge sampling point where k == target (bounded).
    task automatic at_k(input int target);
        int guard = 0;
        while (k != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) check("reach_k", k, target);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #($urandom_range(1, 8));
        reset = 1'b1;
    endtask

    task automatic assert_reset(input string tag);
        #($urandom_range(1, 3));
        reset = 1'b0;
        #1;
        check_reset_state(tag);
    endtask

    initial begin
        // Reset held for three clocks.
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst_hold");

        release_reset();
        counting = 1'b1;
        at_k(0);    check("A_pt_k0", a_pt, 1'b0);
                    check("A_fs_k0", a_fs, 1'b1);
                    check("A_von_k0", a_von, 1'b1);
        at_k(1);    check("A_pt_k1", a_pt, 1'b1);
                    check("A_x_k1", a_x, 0);
        at_k(2);    check("A_pt_k2", a_pt, 1'b0);
                    check("A_x_k2", a_x, 1);
        at_k(1113); check("B_von_19_11", {b_x, b_y, b_von}, {10'd19, 10'd11, 1'b1});
        at_k(1152); check("B_von_0_12", {b_x, b_y, b_von}, {10'd0, 10'd12, 1'b0});
        at_k(1278); check("A_von_639", {a_x, a_von}, {10'd639, 1'b1});
        at_k(1280); check("A_von_640", {a_x, a_von}, {10'd640, 1'b0});
        at_k(1310); check("A_hs_655", {a_x, a_hs}, {10'd655, 1'b1});
        at_k(1312); check("A_hs_656", {a_x, a_hs}, {10'd656, 1'b0});
        at_k(1343); check("B_vs_y13", {b_y, b_vs}, {10'd13, 1'b0});
        at_k(1344); check("B_vs_y14", {b_y, b_vs}, {10'd14, 1'b1});
        at_k(1502); check("A_hs_751", {a_x, a_hs}, {10'd751, 1'b0});
        at_k(1504); check("A_hs_752", {a_x, a_hs}, {10'd752, 1'b1});
        at_k(1598); check("A_le_a", {a_x, a_y, a_le}, {10'd799, 10'd0, 1'b1});
        at_k(1599); check("A_le_b", {a_x, a_y, a_le}, {10'd799, 10'd0, 1'b1});
        at_k(1600); check("A_wrap", {a_x, a_y, a_le}, {10'd0, 10'd1, 1'b0});
        at_k(1823); check("B_last", {b_x, b_y, b_le, b_fs}, {10'd31, 10'd18, 1'b1, 1'b0});
        at_k(1824); check("B_frame", {b_x, b_y, b_fs}, {10'd0, 10'd0, 1'b1});
        at_k(1830);
        counting = 1'b0;
        check("B_von_ticks", b_von_ticks, 240);
        check("B_hs_ticks", b_hs_ticks, 95);
        check("B_vs_ticks", b_vs_ticks, 64);
        check("A_hs_clks", a_hs_clks, 192);

        // Asynchronous reset while dut_b is inside its hsync pulse at (25,7).
        assert_reset("rst_a");
        repeat (2) @(posedge clk);
        release_reset();
        at_k(748);
        check("B_pre_rst", {b_x, b_y, b_hs}, {10'd25, 10'd7, 1'b1});
        assert_reset("rst_mid_hsync");
        repeat (2) @(posedge clk);

        // Random run lengths and reset timing.
        for (int it = 0; it < 8; it++) begin
            release_reset();
            repeat ($urandom_range(20, 4000)) @(posedge clk);
            assert_reset("rst_rand");
            repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        #20;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
